// File: rtl/ext_pkg.sv
// Shared types for the field-extension pipeline: extension modes and the
// occupancy encoding of the two-entry output buffer.
package ext_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ZEXT     = 2'd0;
  localparam mode_t MODE_SEXT     = 2'd1;
  localparam mode_t MODE_SEXT_SHL = 2'd2;
  localparam mode_t MODE_UPPER    = 2'd3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/ext_skid_buf.sv
// Two-entry valid/ready buffer. The main entry drives the output; the skid
// entry absorbs the one beat that can arrive while the output is stalled, so
// in_ready is a registered state decode and never waits on out_ready.
module ext_skid_buf
  import ext_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   st_p1;
  buf_state_t   st_nxt;
  logic [W-1:0] main_p1;
  logic [W-1:0] skid_p1;
  logic         in_xfer;
  logic         out_xfer;
  logic         load_main;
  logic         load_skid;
  logic         skid_to_main;

  assign in_ready  = (st_p1 != FULL) && !rst;
  assign out_valid = (st_p1 != EMPTY);
  assign out_data  = main_p1;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Next occupancy and which register captures what this cycle.
  always_comb begin
    st_nxt       = st_p1;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (st_p1)
      EMPTY: begin
        if (in_xfer) begin
          load_main = 1'b1;
          st_nxt    = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          st_nxt    = FULL;
        end else if (out_xfer) begin
          st_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          skid_to_main = 1'b1;
          st_nxt       = ONE;
        end
      end
      default: st_nxt = EMPTY;
    endcase
  end

  // Occupancy register; reset discards whatever is buffered.
  always_ff @(posedge clk) begin
    if (rst) st_p1 <= EMPTY;
    else     st_p1 <= st_nxt;
  end

  // ---- stage p1: main entry, cleared on reset so the output reads zero ----
  always_ff @(posedge clk) begin
    if (rst)               main_p1 <= '0;
    else if (load_main)    main_p1 <= in_data;
    else if (skid_to_main) main_p1 <= skid_p1;
  end

  // Skid entry holds the overflow beat; its contents are ignored unless FULL.
  always_ff @(posedge clk) begin
    if (load_skid) skid_p1 <= in_data;
  end

endmodule

// File: rtl/ext_unit_pipe.sv
// Widens an IN_W-bit instruction field to OUT_W bits (zero/sign extend,
// sign extend and shift, or upper placement) and hands the result, with a
// shift-overflow flag, to the ALU side through a two-entry skid buffer.
module ext_unit_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  if (IN_W < 2 || OUT_W < IN_W || SHAMT < 0 || SHAMT >= OUT_W) begin : g_bad_params
    $error("ext_unit_pipe: illegal IN_W/OUT_W/SHAMT combination");
  end

  // Returns {ovf, result}. The shifted path is evaluated SHAMT bits wider so
  // the discarded bits can be compared with the surviving sign bit.
  function automatic logic [OUT_W:0] extend(input logic [IN_W-1:0] d,
                                            input mode_t mode);
    logic signed [IN_W-1:0]        ds;
    logic signed [OUT_W-1:0]       sx;
    logic [OUT_W-1:0]              zx;
    logic signed [OUT_W+SHAMT-1:0] wide;
    logic [SHAMT:0]                top;
    logic [OUT_W-1:0]              res;
    logic                          ovf;
    res  = '0;
    ovf  = 1'b0;
    ds   = d;
    sx   = OUT_W'(ds);
    zx   = OUT_W'(d);
    wide = (OUT_W+SHAMT)'(sx) <<< SHAMT;
    top  = wide[OUT_W+SHAMT-1:OUT_W-1];
    case (mode)
      MODE_ZEXT: res = zx;
      MODE_SEXT: res = sx;
      MODE_SEXT_SHL: begin
        res = wide[OUT_W-1:0];
        ovf = !((&top) || !(|top));
      end
      MODE_UPPER: res = zx << (OUT_W - IN_W);
      default:    res = '0;
    endcase
    return {ovf, res};
  endfunction

  logic [OUT_W:0] ext_p0;
  logic [OUT_W:0] pay_p1;

  // ---- stage p0: combinational extension of the incoming beat ----
  assign ext_p0 = extend(in_data, in_mode);

  // ---- stage p1: registered result presented through the skid buffer ----
  ext_skid_buf #(
    .W(OUT_W + 1)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (ext_p0),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pay_p1)
  );

  assign out_data = pay_p1[OUT_W-1:0];
  assign out_ovf  = pay_p1[OUT_W];

endmodule

// File: doc/ext_unit_pipe.md
Name: ext_unit_pipe

Overview:
- Parametrised, pipelined successor to the fixed 2-to-8-bit registered sign extender.
- Widens an IN_W-bit field to OUT_W bits in one of four modes: zero-extend, sign-extend, sign-extend then shift left, or upper-immediate placement.
- Sits between instruction-field decode and the ALU/branch-target path.
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer, so it sustains one transfer per cycle and tolerates back-pressure.

Parameters:
- IN_W, 16, input field width; legal range 2..OUT_W.
- OUT_W, 32, output width; must be >= IN_W.
- SHAMT, 2, left-shift amount for MODE_SEXT_SHL; legal range 0..OUT_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept an input beat
- in_data  in  IN_W  field to extend
- in_mode  in  2  extension mode, sampled with in_data
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- out_data  out  OUT_W  extended result
- out_ovf  out  1  set when MODE_SEXT_SHL discarded significant bits

Behaviour:
- Only clk edges are used. rst is sampled on a clk edge and overrides every other input.
- Reset values:
  - out_valid=0, out_data=0, out_ovf=0.
  - Both buffer entries are invalid.
  - in_ready=0 while rst=1, and 1 from the first cycle after rst deasserts.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Latency: a beat accepted at edge N is presented at out_* after edge N, assuming the output is empty or draining.
- Mode arithmetic (computed combinationally on the input beat, then registered):
  - 0 ZEXT: {(OUT_W-IN_W) zeros, d}.
  - 1 SEXT: {(OUT_W-IN_W) copies of d[IN_W-1], d}.
  - 2 SEXT_SHL:
    - Result = SEXT(d) << SHAMT, truncated to OUT_W.
    - ovf=1 iff the SHAMT discarded top bits of SEXT(d) are not all equal to the result MSB; otherwise ovf=0.
  - 3 UPPER: d placed in bits [OUT_W-1:OUT_W-IN_W], lower bits zero.
  - out_ovf is 0 in every mode except 2.
- Skid buffer: main register drives out_*; the skid register holds one extra beat. States:
  - EMPTY: main invalid.
    - Input transfer -> ONE.
  - ONE: main valid, skid invalid.
    - Input transfer and output transfer together -> ONE; main is replaced by the new beat.
    - Input transfer only -> FULL; the new beat goes to skid.
    - Output transfer only -> EMPTY.
  - FULL: main and skid valid.
    - Output transfer -> ONE; skid moves to main.
    - No input transfer is possible in this state.
- in_ready is a pure register output: in_ready = !(skid valid) and !rst. It never depends combinationally on out_ready.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.
- out_data and out_ovf are held stable while out_valid && !out_ready.
- Reset mid-operation discards both buffered beats. out_valid falls at the reset edge.
- A beat presented while in_ready=0 is not accepted. The source must hold it until accepted.
- Illegal parameter combinations (OUT_W<IN_W, SHAMT>=OUT_W) fail at elaboration via a generate-time check.

Decomposition:
- Package ext_pkg holds:
  - The mode constants MODE_ZEXT=2'd0, MODE_SEXT=2'd1, MODE_SEXT_SHL=2'd2, MODE_UPPER=2'd3.
  - The 2-bit mode type.
  - The buffer-state encoding EMPTY/ONE/FULL.
- Sub-module ext_skid_buf, parametrised on payload width (OUT_W+1), implements the 2-entry handshake buffer.
- The top computes the extension combinationally and feeds the result plus ovf into ext_skid_buf.

Test Plan:
- IN_W=16, OUT_W=32: mode 1, d=16'h8001, out_ready=1 -> out_data=32'hFFFF8001 one cycle later, out_ovf=0. Mode 0, same d -> 32'h00008001.
- Mode 2, SHAMT=2, d=16'h7FFF -> 32'h0001FFFC, ovf=0. IN_W=OUT_W=16 with d=16'h4000 -> 16'h0000, ovf=1.
- Mode 3, d=16'h1234 -> 32'h12340000, ovf=0.
- Back-pressure: stream 4 beats with out_ready=0.
  - Two beats are accepted; in_ready drops after the 2nd.
  - Raising out_ready drains them in order; throughput returns to one beat per cycle with no loss.
- Streaming: in_valid=1 and out_ready=1 continuously for 100 random beats -> 100 outputs, in order, bit-exact against the reference model, in_ready never 0.
- Reset: assert rst with 2 beats buffered -> next cycle out_valid=0, out_data=0, in_ready=0. After deassert, in_ready=1 and the first new beat appears correctly.
